// File: rtl/noc_pkg.sv
// Shared NoC flit types and field positions for the merge/split tree.
package noc_pkg;
  localparam int FLIT_W  = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic              src_t;

  localparam src_t SRC_IN0 = 1'b0;
  localparam src_t SRC_IN1 = 1'b1;
endpackage

// File: rtl/merge_inbuf.sv
// One-entry holding register for a merge input. A grant and a new load in the
// same cycle replace the old flit, so a streaming input never bubbles.
module merge_inbuf
  import noc_pkg::*;
#(
  parameter int W = FLIT_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         grant,
  output logic         in_ready,
  output logic         buf_v,
  output logic [W-1:0] buf_data
);

  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign in_ready = !v_q || grant;
  assign load     = in_valid && in_ready;
  assign buf_v    = v_q;
  assign buf_data = data_q;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (load) begin
      v_d    = 1'b1;
      data_d = in_data;
    end else if (grant) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/merge21_rr.sv
// 2-to-1 round-robin flit merge with per-input holding buffers, a registered
// output carrying a source tag, and saturating per-input delivery counters.
module merge21_rr
  import noc_pkg::*;
#(
  parameter int W  = FLIT_W,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in0_valid,
  input  logic [W-1:0]  in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [W-1:0]  in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_src,
  input  logic          out_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic         buf0_v, buf1_v;
  logic [W-1:0] buf0_data, buf1_data;
  logic         grant0, grant1, out_free;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  src_t         out_src_q, out_src_d;
  src_t         rr_last_q, rr_last_d;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  merge_inbuf #(.W(W)) u_buf0 (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in0_valid), .in_data(in0_data), .grant(grant0),
    .in_ready(in0_ready), .buf_v(buf0_v), .buf_data(buf0_data)
  );

  merge_inbuf #(.W(W)) u_buf1 (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in1_valid), .in_data(in1_data), .grant(grant1),
    .in_ready(in1_ready), .buf_v(buf1_v), .buf_data(buf1_data)
  );

  assign out_free = !out_valid_q || out_ready;

  // On a tie the input that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (out_free) begin
      if (buf0_v && buf1_v) begin
        if (rr_last_q == SRC_IN0) grant1 = 1'b1;
        else                      grant0 = 1'b1;
      end else if (buf0_v) begin
        grant0 = 1'b1;
      end else if (buf1_v) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_last_d   = rr_last_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (grant0 || grant1) begin
      out_valid_d = 1'b1;
      out_data_d  = grant1 ? buf1_data : buf0_data;
      out_src_d   = grant1 ? SRC_IN1 : SRC_IN0;
      rr_last_d   = grant1 ? SRC_IN1 : SRC_IN0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (grant0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CW'(1);
    if (grant1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_IN0;
      rr_last_q   <= SRC_IN1;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_last_q   <= rr_last_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_merge21_rr.sv
// Scoreboard bench for merge21_rr: directed streams per input, expected
// {src,flit} order pushed up front and checked by an output monitor.
module tb_merge21_rr;
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       in0_valid = 1'b0, in1_valid = 1'b0;
  logic [8:0] in0_data = '0, in1_data = '0;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_src;
  logic [8:0] out_data;
  logic       out_ready = 1'b1;
  logic [7:0] cnt0, cnt1;

  logic       s_in0_ready, s_in1_ready, s_out_valid, s_out_src;
  logic [8:0] s_out_data;
  logic [3:0] s_cnt0, s_cnt1;

  merge21_rr #(.W(9), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  merge21_rr #(.W(9), .CW(4)) dut_sat (
    .CLK(CLK), .RESET(RESET),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(s_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_src(s_out_src),
    .out_ready(out_ready), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] exp_q[$];
  logic flush = 1'b0;
  int pop_n = 0;
  int pop_cyc[256];

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Input drivers: hold valid/data until a transfer is seen at the edge.
  initial begin
    logic x0;
    forever begin
      @(negedge CLK);
      x0 = in0_valid && in0_ready && !RESET;
      @(posedge CLK);
      #1;
      if (flush) begin
        q0.delete();
        in0_valid = 1'b0;
      end else begin
        if (x0) in0_valid = 1'b0;
        if (!in0_valid && q0.size() > 0) begin
          in0_data  = q0.pop_front();
          in0_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    logic x1;
    forever begin
      @(negedge CLK);
      x1 = in1_valid && in1_ready && !RESET;
      @(posedge CLK);
      #1;
      if (flush) begin
        q1.delete();
        in1_valid = 1'b0;
      end else begin
        if (x1) in1_valid = 1'b0;
        if (!in1_valid && q1.size() > 0) begin
          in1_data  = q1.pop_front();
          in1_valid = 1'b1;
        end
      end
    end
  end

  // Output monitor: every accepted output must match the scoreboard head.
  initial forever begin
    logic [9:0] e;
    @(negedge CLK);
    if (!RESET && out_valid && out_ready) begin
      if (pop_n < 256) pop_cyc[pop_n] = cyc;
      pop_n++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {22'd0, out_src, out_data}, 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] out src=%0d data=0x%03h (exp src=%0d data=0x%03h)",
                 out_src, out_data, e[9], e[8:0]);
        check("out_flit", {22'd0, out_src, out_data}, {22'd0, e});
      end
    end
  end

  task automatic wait_idle(string nm, int budget);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || in0_valid || in1_valid ||
            exp_q.size() != 0 || out_valid) && k < budget) begin
      tick();
      k++;
    end
    check({nm, "_drained"}, (k < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_burst(string nm, int base, int n);
    check({nm, "_count"}, pop_n - base, n);
    check({nm, "_spacing"}, pop_cyc[pop_n-1] - pop_cyc[base], n - 1);
  endtask

  initial begin
    int base;
    #1 RESET = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {23'd0, out_data}, 0);
    check("rst_out_src", {31'd0, out_src}, 0);
    check("rst_cnt0", {24'd0, cnt0}, 0);
    check("rst_cnt1", {24'd0, cnt1}, 0);
    tick();
    RESET = 1'b0;
    tick();
    check("rst_in0_ready", {31'd0, in0_ready}, 1);
    check("rst_in1_ready", {31'd0, in1_ready}, 1);

    // Single stream on in0.
    base = pop_n;
    exp_q.push_back({1'b0, 9'h0A3});
    exp_q.push_back({1'b0, 9'h15F});
    exp_q.push_back({1'b0, 9'h1FF});
    q0.push_back(9'h0A3); q0.push_back(9'h15F); q0.push_back(9'h1FF);
    wait_idle("single", 40);
    check_burst("single", base, 3);
    check("single_cnt0", {24'd0, cnt0}, 3);
    check("single_cnt1", {24'd0, cnt1}, 0);

    // Contention: alternating service starting with in0 after reset.
    do_reset();
    base = pop_n;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({1'b0, 9'(i)});
      exp_q.push_back({1'b1, 9'(9'h100 + i)});
      q0.push_back(9'(i));
      q1.push_back(9'(9'h100 + i));
    end
    wait_idle("contend", 60);
    check_burst("contend", base, 8);
    check("contend_cnt0", {24'd0, cnt0}, 4);
    check("contend_cnt1", {24'd0, cnt1}, 4);

    // Backpressure: output holds, both buffers fill, then drain in order.
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 9'h011}); exp_q.push_back({1'b1, 9'h111});
    exp_q.push_back({1'b0, 9'h012}); exp_q.push_back({1'b1, 9'h112});
    exp_q.push_back({1'b0, 9'h013}); exp_q.push_back({1'b1, 9'h113});
    q0.push_back(9'h011); q0.push_back(9'h012); q0.push_back(9'h013);
    q1.push_back(9'h111); q1.push_back(9'h112); q1.push_back(9'h113);
    repeat (5) tick();
    check("bp_out_valid", {31'd0, out_valid}, 1);
    check("bp_out_data", {23'd0, out_data}, 32'h011);
    check("bp_in0_ready", {31'd0, in0_ready}, 0);
    check("bp_in1_ready", {31'd0, in1_ready}, 0);
    out_ready = 1'b1;
    wait_idle("bp", 60);

    // in1 streaming alone: buffer reloads on grant, ready never drops.
    base = pop_n;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 9'(9'h1A0 + i)});
      q1.push_back(9'(9'h1A0 + i));
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      check("stream_in1_ready", {31'd0, in1_ready}, 1);
    end
    wait_idle("stream", 40);
    check_burst("stream", base, 5);

    // Saturation: the CW=4 instance sticks at 15 after 20 flits.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back({1'b0, 9'(9'h040 + i)});
      q0.push_back(9'(9'h040 + i));
    end
    wait_idle("sat", 100);
    check("sat_cnt0_cw4", {28'd0, s_cnt0}, 15);
    check("sat_cnt0_cw8", {24'd0, cnt0}, 20);

    // Asynchronous reset with both buffers full and output held.
    out_ready = 1'b0;
    q0.push_back(9'h0B1); q0.push_back(9'h0B2);
    q1.push_back(9'h1B1); q1.push_back(9'h1B2);
    repeat (4) tick();
    check("mid_pre_valid", {31'd0, out_valid}, 1);
    check("mid_pre_in0_ready", {31'd0, in0_ready}, 0);
    check("mid_pre_in1_ready", {31'd0, in1_ready}, 0);
    #1 RESET = 1'b1;
    flush = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_data", {23'd0, out_data}, 0);
    check("mid_rst_src", {31'd0, out_src}, 0);
    check("mid_rst_cnt0", {24'd0, cnt0}, 0);
    check("mid_rst_cnt1", {24'd0, cnt1}, 0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 9'h0C1});
    exp_q.push_back({1'b1, 9'h1C1});
    q0.push_back(9'h0C1);
    q1.push_back(9'h1C1);
    wait_idle("post_rst", 40);
    check("post_rst_cnt0", {24'd0, cnt0}, 1);
    check("post_rst_cnt1", {24'd0, cnt1}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
